// File: rtl/bypass_pkg.sv
// Shared types for the execute-stage bypass unit: operand-source encoding and pipeline entry.
// Combinational helpers only; no latency, no backpressure.
// Entry widths follow BP_DWIDTH/BP_RWIDTH; module parameters default to these.
package bypass_pkg;

    localparam int BP_DWIDTH = 32;
    localparam int BP_RWIDTH = 5;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic                 valid;
        logic                 regwren;
        logic                 is_load;
        logic [BP_RWIDTH-1:0] rd;
        logic [BP_DWIDTH-1:0] data;
    } stage_entry_t;

    // x0 is never a real producer, so an rd of zero can never match.
    function automatic logic entry_matches(input stage_entry_t e, input logic [BP_RWIDTH-1:0] rs);
        return e.valid & e.regwren & (e.rd != '0) & (e.rd == rs);
    endfunction

endpackage

// File: rtl/operand_fwd_mux.sv
// Per-operand source select: EX/MEM over MEM/WB over register file, flags unresolvable RAW.
// Purely combinational; hazard asks upstream to hold the consumer (BYPASS_WB_STAGE_EN enables MEM/WB forwarding).
// No backpressure of its own.
module operand_fwd_mux
    import bypass_pkg::*;
#(
    parameter int DWIDTH = BP_DWIDTH,
    parameter int RWIDTH = BP_RWIDTH
) (
    input  logic [RWIDTH-1:0] rs,
    input  logic [DWIDTH-1:0] rf_data,
    input  stage_entry_t      exmem,
    input  stage_entry_t      memwb,
    output logic [DWIDTH-1:0] op,
    output fwd_sel_e          sel,
    output logic              hazard
);

    logic ex_hit;
    logic wb_hit;
    logic unused_memwb_is_load;

    assign ex_hit               = entry_matches(exmem, rs);
    assign wb_hit               = entry_matches(memwb, rs);
    assign unused_memwb_is_load = memwb.is_load;

    always_comb begin
        sel    = FWD_RF;
        hazard = 1'b0;
        if (ex_hit) begin
            // Load data is not back from memory yet; only a one-cycle bubble helps.
            if (exmem.is_load) begin
                hazard = 1'b1;
            end else begin
                sel = FWD_EXMEM;
            end
        end else if (wb_hit) begin
`ifdef BYPASS_WB_STAGE_EN
            sel = FWD_MEMWB;
`else
            hazard = 1'b1;
`endif
        end
    end

    always_comb begin
        case (sel)
            FWD_EXMEM: op = exmem.data;
            FWD_MEMWB: op = memwb.data;
            default:   op = rf_data;
        endcase
    end

endmodule

// File: rtl/ex_bypass_unit.sv
// Execute-stage bypass: EX/MEM and MEM/WB result registers, RF writeback, operand forwarding, hazard flag.
// Forwardable 1 cycle after EX (EX/MEM), 2 cycles after (MEM/WB); RF written at the end of MEM/WB.
// stall_i holds both registers and suppresses writeback; hazard_o does not hold this unit. Option: BYPASS_WB_STAGE_EN.
module ex_bypass_unit
    import bypass_pkg::*;
#(
    parameter int DWIDTH = BP_DWIDTH,
    parameter int RWIDTH = BP_RWIDTH
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stall_i,
    input  logic              ex_valid_i,
    input  logic              ex_regwren_i,
    input  logic              ex_is_load_i,
    input  logic [RWIDTH-1:0] ex_rd_i,
    input  logic [DWIDTH-1:0] ex_res_i,
    input  logic [DWIDTH-1:0] mem_rdata_i,
    input  logic [RWIDTH-1:0] ex_rs1_i,
    input  logic [RWIDTH-1:0] ex_rs2_i,
    input  logic [DWIDTH-1:0] rf_rs1_data_i,
    input  logic [DWIDTH-1:0] rf_rs2_data_i,
    output logic [DWIDTH-1:0] op1_o,
    output logic [DWIDTH-1:0] op2_o,
    output logic [1:0]        fwd_sel1_o,
    output logic [1:0]        fwd_sel2_o,
    output logic              hazard_o,
    output logic              wb_valid_o,
    output logic [RWIDTH-1:0] wb_rd_o,
    output logic [DWIDTH-1:0] wb_data_o
);

    stage_entry_t exmem_q, exmem_d;
    stage_entry_t memwb_q, memwb_d;
    fwd_sel_e     sel1, sel2;
    logic         hazard1, hazard2;

    always_comb begin
        exmem_d         = '{valid:   ex_valid_i,
                            regwren: ex_regwren_i,
                            is_load: ex_is_load_i,
                            rd:      ex_rd_i,
                            data:    ex_res_i};
        // Loads pick up their memory data on the way into MEM/WB.
        memwb_d         = exmem_q;
        memwb_d.data    = exmem_q.is_load ? mem_rdata_i : exmem_q.data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exmem_q <= '0;
            memwb_q <= '0;
        end else if (!stall_i) begin
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

    assign wb_valid_o = memwb_q.valid & memwb_q.regwren & (memwb_q.rd != '0) & ~stall_i;
    assign wb_rd_o    = memwb_q.rd;
    assign wb_data_o  = memwb_q.data;

    operand_fwd_mux #(.DWIDTH(DWIDTH), .RWIDTH(RWIDTH)) u_fwd_rs1 (
        .rs      (ex_rs1_i),
        .rf_data (rf_rs1_data_i),
        .exmem   (exmem_q),
        .memwb   (memwb_q),
        .op      (op1_o),
        .sel     (sel1),
        .hazard  (hazard1)
    );

    operand_fwd_mux #(.DWIDTH(DWIDTH), .RWIDTH(RWIDTH)) u_fwd_rs2 (
        .rs      (ex_rs2_i),
        .rf_data (rf_rs2_data_i),
        .exmem   (exmem_q),
        .memwb   (memwb_q),
        .op      (op2_o),
        .sel     (sel2),
        .hazard  (hazard2)
    );

    assign fwd_sel1_o = sel1;
    assign fwd_sel2_o = sel2;
    assign hazard_o   = hazard1 | hazard2;

endmodule

// File: tb/tb_ex_bypass_unit.sv
// Directed bench for ex_bypass_unit with an in-flight-instruction model checked every negedge.
module tb_ex_bypass_unit;

    localparam int DW = 32;
    localparam int RW = 5;
`ifdef BYPASS_WB_STAGE_EN
    localparam bit WB_FWD = 1'b1;
`else
    localparam bit WB_FWD = 1'b0;
`endif

    logic          clk;
    logic          reset_n;
    logic          stall_i;
    logic          ex_valid_i;
    logic          ex_regwren_i;
    logic          ex_is_load_i;
    logic [RW-1:0] ex_rd_i;
    logic [DW-1:0] ex_res_i;
    logic [DW-1:0] mem_rdata_i;
    logic [RW-1:0] ex_rs1_i;
    logic [RW-1:0] ex_rs2_i;
    logic [DW-1:0] rf_rs1_data_i;
    logic [DW-1:0] rf_rs2_data_i;
    logic [DW-1:0] op1_o;
    logic [DW-1:0] op2_o;
    logic [1:0]    fwd_sel1_o;
    logic [1:0]    fwd_sel2_o;
    logic          hazard_o;
    logic          wb_valid_o;
    logic [RW-1:0] wb_rd_o;
    logic [DW-1:0] wb_data_o;

    int checks = 0;
    int errors = 0;
    int wr_x9  = 0;
    int wr_x10 = 0;
    int wr_disc = 0;

    ex_bypass_unit dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .stall_i       (stall_i),
        .ex_valid_i    (ex_valid_i),
        .ex_regwren_i  (ex_regwren_i),
        .ex_is_load_i  (ex_is_load_i),
        .ex_rd_i       (ex_rd_i),
        .ex_res_i      (ex_res_i),
        .mem_rdata_i   (mem_rdata_i),
        .ex_rs1_i      (ex_rs1_i),
        .ex_rs2_i      (ex_rs2_i),
        .rf_rs1_data_i (rf_rs1_data_i),
        .rf_rs2_data_i (rf_rs2_data_i),
        .op1_o         (op1_o),
        .op2_o         (op2_o),
        .fwd_sel1_o    (fwd_sel1_o),
        .fwd_sel2_o    (fwd_sel2_o),
        .hazard_o      (hazard_o),
        .wb_valid_o    (wb_valid_o),
        .wb_rd_o       (wb_rd_o),
        .wb_data_o     (wb_data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: the last two instructions issued, youngest first.
    typedef struct {
        bit          v;
        bit          w;
        bit          l;
        logic [4:0]  rd;
        logic [31:0] d;
    } instr_t;
    instr_t inflight[$];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inflight.delete();
        end else if (!stall_i) begin
            instr_t n;
            if (inflight.size() > 0 && inflight[0].l) inflight[0].d = mem_rdata_i;
            n.v  = ex_valid_i;
            n.w  = ex_regwren_i;
            n.l  = ex_is_load_i;
            n.rd = ex_rd_i;
            n.d  = ex_res_i;
            inflight.push_front(n);
            if (inflight.size() > 2) void'(inflight.pop_back());
        end
    end

    function automatic void expect_operand(input logic [4:0] rs, input logic [31:0] rf,
                                           output logic [31:0] op, output logic [1:0] sel,
                                           output bit haz);
        op  = rf;
        sel = 2'b00;
        haz = 1'b0;
        for (int age = 0; age < inflight.size(); age++) begin
            if (inflight[age].v && inflight[age].w && inflight[age].rd != 0 && inflight[age].rd == rs) begin
                if (age == 0 && !inflight[age].l) begin
                    sel = 2'b01;
                    op  = inflight[age].d;
                end else if (age == 1 && WB_FWD) begin
                    sel = 2'b10;
                    op  = inflight[age].d;
                end else begin
                    haz = 1'b1;
                end
                return;
            end
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : cmp
        logic [31:0] e_op1, e_op2, e_wd;
        logic [1:0]  e_s1, e_s2;
        logic [4:0]  e_rd;
        bit          h1, h2, e_wbv;
        expect_operand(ex_rs1_i, rf_rs1_data_i, e_op1, e_s1, h1);
        expect_operand(ex_rs2_i, rf_rs2_data_i, e_op2, e_s2, h2);
        e_wbv = 1'b0;
        e_rd  = '0;
        e_wd  = '0;
        if (inflight.size() == 2) begin
            e_rd  = inflight[1].rd;
            e_wd  = inflight[1].d;
            e_wbv = inflight[1].v && inflight[1].w && inflight[1].rd != 0 && !stall_i;
        end
        chk("model_op1",      op1_o, e_op1);
        chk("model_op2",      op2_o, e_op2);
        chk("model_sel1",     32'(fwd_sel1_o), 32'(e_s1));
        chk("model_sel2",     32'(fwd_sel2_o), 32'(e_s2));
        chk("model_hazard",   32'(hazard_o), 32'(h1 | h2));
        chk("model_wb_valid", 32'(wb_valid_o), 32'(e_wbv));
        chk("model_wb_rd",    32'(wb_rd_o), 32'(e_rd));
        chk("model_wb_data",  wb_data_o, e_wd);
    end

    always @(negedge clk) begin
        if (wb_valid_o) begin
            if (wb_rd_o == 5'd9)  wr_x9++;
            if (wb_rd_o == 5'd10) wr_x10++;
            if (wb_rd_o == 5'd12 || wb_rd_o == 5'd13) wr_disc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit v, input bit w, input bit l, input int rd, input logic [31:0] res);
        ex_valid_i   = v;
        ex_regwren_i = w;
        ex_is_load_i = l;
        ex_rd_i      = 5'(rd);
        ex_res_i     = res;
    endtask

    task automatic idle();
        issue(1'b0, 1'b0, 1'b0, 0, 32'h0);
        ex_rs1_i      = 5'd0;
        ex_rs2_i      = 5'd0;
        rf_rs1_data_i = 32'h0;
        rf_rs2_data_i = 32'h0;
        mem_rdata_i   = 32'h0;
        stall_i       = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        idle();
        rf_rs1_data_i = 32'hAAAA;
        rf_rs2_data_i = 32'hBBBB;
        tick();
        tick();
        chk("reset_wb_valid", 32'(wb_valid_o), 32'h0);
        chk("reset_wb_rd",    32'(wb_rd_o), 32'h0);
        chk("reset_wb_data",  wb_data_o, 32'h0);
        chk("reset_hazard",   32'(hazard_o), 32'h0);
        chk("reset_sel1",     32'(fwd_sel1_o), 32'h0);
        chk("reset_op1",      op1_o, 32'hAAAA);
        chk("reset_op2",      op2_o, 32'hBBBB);
        reset_n = 1'b1;
        idle();
        tick();

        // Back-to-back dependency
        issue(1'b1, 1'b1, 1'b0, 5, 32'd7);
        tick();
        idle();
        ex_rs1_i = 5'd5;
        #1;
        chk("b2b_sel1",   32'(fwd_sel1_o), 32'h1);
        chk("b2b_op1",    op1_o, 32'd7);
        chk("b2b_hazard", 32'(hazard_o), 32'h0);
        tick();

        // Distance two
        idle();
        issue(1'b1, 1'b1, 1'b0, 6, 32'h55);
        tick();
        idle();
        tick();
        idle();
        ex_rs2_i      = 5'd6;
        rf_rs2_data_i = 32'h1111;
        #1;
`ifdef BYPASS_WB_STAGE_EN
        chk("d2_sel2",   32'(fwd_sel2_o), 32'h2);
        chk("d2_op2",    op2_o, 32'h55);
        chk("d2_hazard", 32'(hazard_o), 32'h0);
`else
        chk("d2_hazard", 32'(hazard_o), 32'h1);
        chk("d2_sel2",   32'(fwd_sel2_o), 32'h0);
        chk("d2_op2",    op2_o, 32'h1111);
`endif
        chk("d2_wb_valid", 32'(wb_valid_o), 32'h1);
        chk("d2_wb_rd",    32'(wb_rd_o), 32'd6);
        chk("d2_wb_data",  wb_data_o, 32'h55);
        tick();
        idle();
        ex_rs2_i      = 5'd6;
        rf_rs2_data_i = 32'h55;
        #1;
        chk("d2_after_sel2",   32'(fwd_sel2_o), 32'h0);
        chk("d2_after_op2",    op2_o, 32'h55);
        chk("d2_after_hazard", 32'(hazard_o), 32'h0);
        tick();

        // Load-use
        idle();
        issue(1'b1, 1'b1, 1'b1, 7, 32'h100);
        tick();
        idle();
        ex_rs1_i    = 5'd7;
        mem_rdata_i = 32'hDEAD;
        #1;
        chk("lu_hazard", 32'(hazard_o), 32'h1);
        chk("lu_sel1",   32'(fwd_sel1_o), 32'h0);
        chk("lu_op1",    op1_o, 32'h0);
        tick();
        idle();
        ex_rs1_i    = 5'd7;
        mem_rdata_i = 32'hBEEF;
        #1;
        chk("lu_wb_valid", 32'(wb_valid_o), 32'h1);
        chk("lu_wb_rd",    32'(wb_rd_o), 32'd7);
        chk("lu_wb_data",  wb_data_o, 32'hDEAD);
`ifdef BYPASS_WB_STAGE_EN
        chk("lu_after_sel1",   32'(fwd_sel1_o), 32'h2);
        chk("lu_after_op1",    op1_o, 32'hDEAD);
        chk("lu_after_hazard", 32'(hazard_o), 32'h0);
`else
        chk("lu_after_hazard", 32'(hazard_o), 32'h1);
`endif
        tick();

        // x0 destination and source
        idle();
        issue(1'b1, 1'b1, 1'b0, 0, 32'h33);
        tick();
        idle();
        #1;
        chk("x0_sel1", 32'(fwd_sel1_o), 32'h0);
        chk("x0_op1",  op1_o, 32'h0);
        tick();
        idle();
        #1;
        chk("x0_wb_valid", 32'(wb_valid_o), 32'h0);
        tick();

        // Both stages hold x8: youngest wins
        issue(1'b1, 1'b1, 1'b0, 8, 32'd3);
        tick();
        issue(1'b1, 1'b1, 1'b0, 8, 32'd9);
        tick();
        idle();
        ex_rs1_i = 5'd8;
        ex_rs2_i = 5'd8;
        #1;
        chk("prio_sel1", 32'(fwd_sel1_o), 32'h1);
        chk("prio_op1",  op1_o, 32'd9);
        chk("prio_op2",  op2_o, 32'd9);
        tick();

        // Stall holds both stages and suppresses writeback
        idle();
        issue(1'b1, 1'b1, 1'b0, 9, 32'h12);
        tick();
        issue(1'b1, 1'b1, 1'b0, 11, 32'h5A);
        tick();
        issue(1'b1, 1'b1, 1'b0, 10, 32'h77);
        stall_i  = 1'b1;
        ex_rs1_i = 5'd11;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_wb_valid", 32'(wb_valid_o), 32'h0);
            chk("stall_op1",      op1_o, 32'h5A);
            tick();
        end
        idle();
        #1;
        chk("release_wb_valid", 32'(wb_valid_o), 32'h1);
        chk("release_wb_rd",    32'(wb_rd_o), 32'd9);
        chk("release_wb_data",  wb_data_o, 32'h12);
        tick();
        #1;
        chk("release_next_rd", 32'(wb_rd_o), 32'd11);
        tick();
        tick();
        chk("x9_write_count",  32'(wr_x9), 32'd1);
        chk("x10_write_count", 32'(wr_x10), 32'd0);

        // Reset with both stages occupied
        idle();
        issue(1'b1, 1'b1, 1'b0, 12, 32'h1);
        tick();
        issue(1'b1, 1'b1, 1'b0, 13, 32'h2);
        tick();
        idle();
        ex_rs1_i      = 5'd13;
        rf_rs1_data_i = 32'hCAFE;
        #1;
        chk("prerst_op1", op1_o, 32'h2);
        reset_n = 1'b0;
        #1;
        chk("rst_wb_valid", 32'(wb_valid_o), 32'h0);
        chk("rst_wb_rd",    32'(wb_rd_o), 32'h0);
        chk("rst_wb_data",  wb_data_o, 32'h0);
        chk("rst_hazard",   32'(hazard_o), 32'h0);
        chk("rst_sel1",     32'(fwd_sel1_o), 32'h0);
        chk("rst_op1",      op1_o, 32'hCAFE);
        tick();
        reset_n = 1'b1;
        idle();
        for (int i = 0; i < 3; i++) tick();
        chk("discarded_writes", 32'(wr_disc), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
